// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX-stage operand forwarding selects for a 5-stage pipeline.
// Optional FWD_STATS_EN adds saturating stall/forward event counters.
module hazard_fwd_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_id_valid,
  input  logic [4:0] io_id_rs1,
  input  logic [4:0] io_id_rs2,
  input  logic [4:0] io_id_rd,
  input  logic       io_id_regwen,
  input  logic       io_id_is_load,
  input  logic       io_id_a_pc,
  input  logic       io_id_b_imm,
  input  logic       io_hold,
  input  logic       io_flush,
  output logic [1:0] io_a_sel,
  output logic [1:0] io_b_sel,
  output logic       io_stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0] io_stall_cnt,
  output logic [15:0] io_fwd_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwen;
    logic       is_load;
  } ent_t;

  localparam logic [1:0] SEL_REG = 2'd0, SEL_ALT = 2'd1, SEL_ALU = 2'd2, SEL_MEM = 2'd3;

  ent_t       ex_q, ex_d, mem_q;
  logic [1:0] a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic [1:0] a_nxt, b_nxt;
  logic       bubble;

  function automatic logic prod(input ent_t e, input logic [4:0] r);
    return e.valid && e.regwen && (e.rd == r) && (r != 5'd0);
  endfunction

  // EX holds the younger producer, so it wins over MEM.
  function automatic logic [1:0] pick(input logic alt, input logic [4:0] r,
                                      input ent_t ex, input ent_t mem);
    if (alt)                return SEL_ALT;
    else if (prod(ex, r))   return SEL_ALU;
    else if (prod(mem, r))  return SEL_MEM;
    else                    return SEL_REG;
  endfunction

  always_comb begin
    io_stall = !reset && io_id_valid && !io_flush && ex_q.is_load &&
               ((!io_id_a_pc && prod(ex_q, io_id_rs1)) ||
                (!io_id_b_imm && prod(ex_q, io_id_rs2)));
    a_nxt  = pick(io_id_a_pc,  io_id_rs1, ex_q, mem_q);
    b_nxt  = pick(io_id_b_imm, io_id_rs2, ex_q, mem_q);
    bubble = io_flush || io_stall || !io_id_valid;
    ex_d   = '0;
    a_sel_d = SEL_REG;
    b_sel_d = SEL_REG;
    if (!bubble) begin
      ex_d    = '{valid: 1'b1, rd: io_id_rd, regwen: io_id_regwen, is_load: io_id_is_load};
      a_sel_d = a_nxt;
      b_sel_d = b_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      a_sel_q <= SEL_REG;
      b_sel_q <= SEL_REG;
    end else if (!io_hold) begin
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
    end
  end

  assign io_a_sel = a_sel_q;
  assign io_b_sel = b_sel_q;

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;
  logic        fwd_ev;

  assign fwd_ev = a_sel_d[1] || b_sel_d[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (!io_hold) begin
      if (io_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (fwd_ev   && fwd_cnt_q   != 16'hFFFF) fwd_cnt_q   <= fwd_cnt_q + 16'd1;
    end
  end

  assign io_stall_cnt = stall_cnt_q;
  assign io_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scenarios then random traffic, checked against a queue-based
// history model of the last two issued pipeline slots.
module tb_hazard_fwd_unit;

  logic       clock = 1'b0;
  logic       reset, io_id_valid, io_id_regwen, io_id_is_load, io_id_a_pc, io_id_b_imm;
  logic       io_hold, io_flush;
  logic [4:0] io_id_rs1, io_id_rs2, io_id_rd;
  logic [1:0] io_a_sel, io_b_sel;
  logic       io_stall;
`ifdef FWD_STATS_EN
  logic [15:0] io_stall_cnt, io_fwd_cnt;
`endif

  hazard_fwd_unit dut (
    .clock(clock), .reset(reset), .io_id_valid(io_id_valid),
    .io_id_rs1(io_id_rs1), .io_id_rs2(io_id_rs2), .io_id_rd(io_id_rd),
    .io_id_regwen(io_id_regwen), .io_id_is_load(io_id_is_load),
    .io_id_a_pc(io_id_a_pc), .io_id_b_imm(io_id_b_imm),
    .io_hold(io_hold), .io_flush(io_flush),
    .io_a_sel(io_a_sel), .io_b_sel(io_b_sel), .io_stall(io_stall)
`ifdef FWD_STATS_EN
    , .io_stall_cnt(io_stall_cnt), .io_fwd_cnt(io_fwd_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { bit v; int rd; bit wen; bit ld; } inst_t;

  inst_t hist[$];          // hist[0] = most recently issued slot (EX), hist[1] = MEM
  int    exp_a, exp_b;
  int    cmp_cnt = 0, err_cnt = 0;
  int    m_stall_cnt = 0, m_fwd_cnt = 0;

  function automatic bit mprod(inst_t e, int r);
    return e.v && e.wen && e.rd == r && r != 0;
  endfunction

  function automatic int msel(bit alt, int r);
    if (alt) return 1;
    for (int i = 0; i < 2; i++) if (mprod(hist[i], r)) return i + 2;
    return 0;
  endfunction

  task automatic check(string tag, int got, int exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    inst_t b;
    b = '{0, 0, 0, 0};
    hist = '{b, b};
    exp_a = 0; exp_b = 0;
    m_stall_cnt = 0; m_fwd_cnt = 0;
  endtask

  // One clock: drive ID/control, check stall before the edge, check selects after.
  task automatic cyc(bit v, int rs1, int rs2, int rd, bit wen, bit ld,
                     bit apc, bit bimm, bit hold, bit flush, bit rst);
    bit    es, bub;
    int    na, nb;
    inst_t n;
    io_id_valid = v; io_id_rs1 = 5'(rs1); io_id_rs2 = 5'(rs2); io_id_rd = 5'(rd);
    io_id_regwen = wen; io_id_is_load = ld; io_id_a_pc = apc; io_id_b_imm = bimm;
    io_hold = hold; io_flush = flush; reset = rst;
    #1;
    es = !rst && v && !flush && hist[0].v && hist[0].ld &&
         ((!apc && mprod(hist[0], rs1)) || (!bimm && mprod(hist[0], rs2)));
    check("stall", io_stall, es);
    na = msel(apc, rs1);
    nb = msel(bimm, rs2);
    @(posedge clock);
    if (rst) clear_model();
    else if (!hold) begin
      bub = flush || es || !v;
      n = bub ? '{0, 0, 0, 0} : '{1, rd, wen, ld};
      hist.push_front(n);
      void'(hist.pop_back());
      exp_a = bub ? 0 : na;
      exp_b = bub ? 0 : nb;
      if (es && m_stall_cnt < 65535) m_stall_cnt++;
      if (!bub && (na >= 2 || nb >= 2) && m_fwd_cnt < 65535) m_fwd_cnt++;
    end
    #1;
    check("a_sel", io_a_sel, exp_a);
    check("b_sel", io_b_sel, exp_b);
`ifdef FWD_STATS_EN
    check("stall_cnt", io_stall_cnt, m_stall_cnt);
    check("fwd_cnt", io_fwd_cnt, m_fwd_cnt);
`endif
  endtask

  // shorthand: ALU op / load / idle
  task automatic alu(int rd, int rs1, int rs2); cyc(1, rs1, rs2, rd, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic lw(int rd, int rs1);           cyc(1, rs1, 0, rd, 1, 1, 0, 1, 0, 0, 0); endtask
  task automatic nop();                         cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    clear_model();
    @(posedge clock); #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 5, 5, 5, 1, 1, 0, 0, 1, 1, 1);
    check("rst_a", io_a_sel, 0);
    check("rst_b", io_b_sel, 0);

    // ADD x5 ; ADD x6,x5,x1
    alu(5, 1, 2); alu(6, 5, 1);
    check("fwd_ex_a", io_a_sel, 2); check("fwd_ex_b", io_b_sel, 0);
    nop(); nop();

    // ADD x5 ; NOP ; SUB x7,x1,x5
    alu(5, 1, 2); nop(); alu(7, 1, 5);
    check("fwd_mem_b", io_b_sel, 3); check("fwd_mem_a", io_a_sel, 0);
    nop(); nop();

    // LW x5 ; ADD x6,x5,x5 -> one stall, one bubble, then MEM forward
    lw(5, 1); alu(6, 5, 5);
    check("lu_bubble_a", io_a_sel, 0);
    alu(6, 5, 5);
    check("lu_fwd_a", io_a_sel, 3); check("lu_fwd_b", io_b_sel, 3);
    nop(); nop();

    // LW x5 ; ADD with flush -> flush wins
    lw(5, 1); cyc(1, 5, 5, 6, 1, 0, 0, 0, 0, 1, 0);
    check("flush_a", io_a_sel, 0); check("flush_b", io_b_sel, 0);
    nop(); nop();

    // x0 never forwards; AUIPC-style a_pc with rs1 match selects pc
    alu(0, 1, 2); alu(6, 0, 0);
    check("x0_a", io_a_sel, 0);
    alu(5, 1, 2); cyc(1, 5, 0, 8, 1, 0, 1, 1, 0, 0, 0);
    check("auipc_a", io_a_sel, 1);
    nop(); nop();

    // rd == rs against older entries only
    alu(5, 5, 5);
    check("self_a", io_a_sel, 0);
    nop(); nop();

    // hold for 3 cycles mid-sequence
    alu(5, 1, 2);
    repeat (3) cyc(1, 5, 1, 6, 1, 0, 0, 0, 1, 0, 0);
    alu(6, 5, 1);
    check("hold_resume_a", io_a_sel, 2);
    nop(); nop();

    // reset mid-stall discards the bubble; next instruction sees no hazard
    lw(5, 1);
    cyc(1, 5, 5, 6, 1, 0, 0, 0, 0, 0, 1);
    alu(6, 5, 5);
    check("post_rst_a", io_a_sel, 0); check("post_rst_b", io_b_sel, 0);

    // random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 49) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
